pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline stage register. Generalises the fixed load/reset stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block with arbitrary payload width and buffer depth. Adds valid/ready handshake, a synchronous flush, and a defined bubble value. Sits between any two pipeline stages; the payload is the concatenated ctrl word, pc, instruction and operands.

---
 rtl/pipe_stage_buf.sv | 93 +++++++++
 tb/tb_pipe_stage_buf.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: DEPTH-entry circular buffer with valid/ready handshake, flush and bubble output.
// Optional stall counter enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_buf #(
    parameter int               WIDTH      = 64,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
    parameter int               CW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    occupancy,
    output logic [31:0]      stall_cycles
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // Ready depends only on the registered count, never on out_ready.
    assign w_in_ready  = (r_count < CW'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid & w_in_ready & ~flush;
    assign w_pop       = w_out_valid & out_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
            if (w_pop)
                r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; stale contents are hidden by the bubble mux.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_push && (r_wp == PW'(gi)))
                    r_mem[gi] <= in_data;
            end
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? r_mem[r_rp] : BUBBLE_VAL;
    assign occupancy = r_count;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] r_stall;

    // Counts head-blocked cycles; saturates and survives flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall <= '0;
        else if (w_out_valid && !out_ready && (r_stall != 32'hFFFF_FFFF))
            r_stall <= r_stall + 32'd1;
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed-step bench for pipe_stage_buf (DEPTH=2) with a queue scoreboard and immediate-assertion checks.
module tb_pipe_stage_buf;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    occupancy;
    logic [31:0]      stall_cycles;

    int unsigned      total_checks = 0;
    int unsigned      passed_checks = 0;
    logic [WIDTH-1:0] sb_q[$];
    int unsigned      stall_model = 0;
    logic [31:0]      stall_snap;

    pipe_stage_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_stall();
`ifdef PIPE_STAGE_STATS_EN
        return 32'(stall_model);
`else
        return 32'd0;
`endif
    endfunction

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
        logic [WIDTH-1:0] head;
        int               sz;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        sz   = sb_q.size();
        head = (sz != 0) ? sb_q[0] : '0;
        check("out_valid", 32'(out_valid), 32'(sz != 0));
        check("out_data",  32'(out_data),  32'(head));
        check("in_ready",  32'(in_ready),  32'(sz < DEPTH));
        check("occupancy", 32'(occupancy), 32'(sz));
        check("stall",     stall_cycles,   exp_stall());
        $display("step v=%0b d=%0h ordy=%0b fl=%0b | out_v=%0b out_d=%0h in_rdy=%0b occ=%0d stall=%0d",
                 v, d, ordy, fl, out_valid, out_data, in_ready, occupancy, stall_cycles);
        if (sz != 0 && !ordy)
            stall_model++;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (ordy && sz != 0)
                void'(sb_q.pop_front());
            if (v && sz < DEPTH)
                sb_q.push_back(d);
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_stall",     stall_cycles,   32'd0);
        rst = 1'b0;

        // Reset mid-stream
        step(1'b1, 16'h000A, 1'b0, 1'b0);
        step(1'b1, 16'h000B, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data",  32'(out_data),  32'd0);
        check("mid_rst_occupancy", 32'(occupancy), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_stall",     stall_cycles,   32'd0);
        sb_q.delete();
        stall_model = 0;
        @(negedge clk);
        rst = 1'b0;

        // Streaming with out_ready held high
        for (int v = 1; v <= 16; v++)
            step(1'b1, 16'(v), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: third push is refused while full
        step(1'b1, 16'h0011, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 1'b0, 1'b0);
        step(1'b1, 16'h0033, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous push and pop at occupancy 1
        step(1'b1, 16'h0005, 1'b0, 1'b0);
        step(1'b1, 16'h0006, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Flush while full, with a same-cycle push and pop request
        step(1'b1, 16'h0021, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 1'b0, 1'b0);
        step(1'b1, 16'h0007, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Stall counting: five blocked cycles, then flush with out_ready high
        step(1'b1, 16'h0044, 1'b0, 1'b0);
        stall_snap = 32'(stall_model);
        repeat (5) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_STATS_EN
        check("stall_delta", stall_cycles - stall_snap, 32'd5);
`else
        check("stall_off", stall_cycles, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
